// File: rtl/qpsk_symbol_mapper_pkg.sv
// qpsk_pkg: shared types and helpers for the QPSK symbol mapper.
//   sample_t    : signed I or Q sample
//   iq_t        : packed {q, i}; q occupies the upper half, matching o_data
//   pair_state_t: chip pairing FSM states
//   out_state_t : output sequencer states
//   GRAY_DEC    : dibit {b_q,b_i} -> phase increment (differential mode)
//   GRAY_ENC    : phase -> {q_neg,i_neg} sign bits (differential mode)
//   map_dibit() : sign bits -> constellation point at +/-ampl
package qpsk_pkg;

  localparam int PKG_SAMPLE_W = 16;

  typedef logic signed [PKG_SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t q;
    sample_t i;
  } iq_t;

  typedef enum logic {WAIT_I, WAIT_Q} pair_state_t;

  typedef enum logic [1:0] {OUT_IDLE, OUT_SYM, OUT_ZERO} out_state_t;

  // Two-bit entries, index k at [2k+1:2k].
  // Decode: 00->0, 01->1, 10->3, 11->2.
  localparam logic [7:0] GRAY_DEC = {2'd2, 2'd3, 2'd1, 2'd0};
  // Encode: 0->(+,+) 00, 1->(-,+) 01, 2->(-,-) 11, 3->(+,-) 10.
  localparam logic [7:0] GRAY_ENC = {2'b10, 2'b11, 2'b01, 2'b00};

  // bits[0] set -> I negative, bits[1] set -> Q negative.
  function automatic iq_t map_dibit(input logic [1:0] bits, input sample_t ampl);
    iq_t s;
    s.i = bits[0] ? -ampl : ampl;
    s.q = bits[1] ? -ampl : ampl;
    return s;
  endfunction

endpackage

// File: rtl/qpsk_symbol_mapper_sym_queue.sv
// sym_queue: QDEPTH-entry synchronous FIFO of iq_t symbols.
//   gclk, grst_n : clock, async active-low reset
//   push, wdata  : write request / symbol
//   pop          : read request (ignored when empty)
//   rdata        : head of queue (valid when !empty)
//   full, empty  : occupancy flags
//   drop         : push refused this cycle (full and no pop)
// A pop in the same cycle as a push on a full queue frees the slot, so
// both are honoured.
module sym_queue
  import qpsk_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic push,
  input  iq_t  wdata,
  input  logic pop,
  output iq_t  rdata,
  output logic full,
  output logic empty,
  output logic drop
);

  localparam int AW = $clog2(QDEPTH);

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_depth
    $error("sym_queue: QDEPTH must be a power of two >= 2");
  end

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wp, rp;
  iq_t         mem [QDEPTH];
  logic        do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/qpsk_symbol_mapper.sv
// qpsk_symbol_mapper: pairs serial chips into dibits, maps them to QPSK
// points, optionally stuffs zeros, and feeds the FIR via valid/ready.
//   i_clk, i_reset : clock, async active-low reset
//   i_sync         : restart pairing (next chip is I); drops a same-cycle chip
//   i_data, i_valid: chip stream from the FIFO, no backpressure
//   o_data         : {Q, I} sample, two's complement, SAMPLE_W each
//   o_valid,i_ready: handshake toward the FIR
//   o_overflow     : sticky, a symbol was dropped on a full queue
//   o_busy         : queue/output/zero run/half-built dibit in progress
// Build option: define QPSK_DIFF_EN for differential QPSK (phase accumulator).
module qpsk_symbol_mapper
  import qpsk_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int AMPL     = 8192,
  parameter int UPSAMPLE = 1,
  parameter int QDEPTH   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sync,
  input  logic                  i_data,
  input  logic                  i_valid,
  output logic [2*SAMPLE_W-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overflow,
  output logic                  o_busy
);

  if (SAMPLE_W != PKG_SAMPLE_W || UPSAMPLE < 1 ||
      AMPL <= 0 || AMPL >= (1 << (SAMPLE_W - 1))) begin : g_bad_cfg
    $error("qpsk_symbol_mapper: unsupported SAMPLE_W/AMPL/UPSAMPLE");
  end

  localparam sample_t AMPL_S = sample_t'(AMPL);
  localparam int      ZW     = $clog2(UPSAMPLE) + 1;

  // ---------------- chip pairing ----------------
  pair_state_t pair_q, pair_d;
  logic        b_i;
  logic        push;
  logic [1:0]  dibit, map_bits;
  iq_t         push_sym;

  always_comb begin
    pair_d = pair_q;
    push   = 1'b0;
    if (i_sync) begin
      pair_d = WAIT_I;
    end else if (i_valid) begin
      case (pair_q)
        WAIT_I:  pair_d = WAIT_Q;
        default: begin
          pair_d = WAIT_I;
          push   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pair_q <= WAIT_I;
      b_i    <= 1'b0;
    end else begin
      pair_q <= pair_d;
      if (!i_sync && i_valid && pair_q == WAIT_I) b_i <= i_data;
    end
  end

  assign dibit = {i_data, b_i};

`ifdef QPSK_DIFF_EN
  // Accumulator advances on every completed dibit, even ones the queue
  // drops, so the transmitted phase stays continuous. i_sync leaves it alone.
  logic [1:0] acc_q, acc_d;

  always_comb begin
    acc_d    = acc_q + GRAY_DEC[{dibit, 1'b0} +: 2];
    map_bits = GRAY_ENC[{acc_d, 1'b0} +: 2];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)  acc_q <= 2'd0;
    else if (push) acc_q <= acc_d;
  end
`else
  assign map_bits = dibit;
`endif

  assign push_sym = map_dibit(map_bits, AMPL_S);

  // ---------------- symbol queue ----------------
  iq_t  q_head;
  logic q_full, q_empty, q_drop, pop;

  sym_queue #(.QDEPTH(QDEPTH)) u_queue (
    .gclk   (i_clk),
    .grst_n (i_reset),
    .push   (push),
    .wdata  (push_sym),
    .pop    (pop),
    .rdata  (q_head),
    .full   (q_full),
    .empty  (q_empty),
    .drop   (q_drop)
  );

  // ---------------- output sequencer ----------------
  out_state_t     os_q, os_d;
  iq_t            od_q, od_d;
  logic           ov_q, ov_d;
  logic [ZW-1:0]  zc_q, zc_d;
  logic           ovf_q;
  logic           xfer, advance;

  assign xfer = ov_q & i_ready;

  always_comb begin
    os_d    = os_q;
    od_d    = od_q;
    ov_d    = ov_q;
    zc_d    = zc_q;
    pop     = 1'b0;
    advance = 1'b0;
    case (os_q)
      OUT_IDLE: advance = 1'b1;
      OUT_SYM: begin
        if (xfer) begin
          if (UPSAMPLE > 1) begin
            os_d = OUT_ZERO;
            od_d = '0;
            zc_d = ZW'(1);
          end else begin
            advance = 1'b1;
          end
        end
      end
      OUT_ZERO: begin
        // zc counts zeros presented; the run ends on the last one's transfer
        if (xfer) begin
          if (zc_q == ZW'(UPSAMPLE - 1)) advance = 1'b1;
          else                           zc_d    = zc_q + ZW'(1);
        end
      end
      default: os_d = OUT_IDLE;
    endcase
    if (advance) begin
      if (!q_empty) begin
        pop  = 1'b1;
        od_d = q_head;
        ov_d = 1'b1;
        os_d = OUT_SYM;
      end else begin
        od_d = '0;
        ov_d = 1'b0;
        os_d = OUT_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      os_q  <= OUT_IDLE;
      od_q  <= '0;
      ov_q  <= 1'b0;
      zc_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      os_q  <= os_d;
      od_q  <= od_d;
      ov_q  <= ov_d;
      zc_q  <= zc_d;
      ovf_q <= ovf_q | q_drop;
    end
  end

  assign o_data     = od_q;
  assign o_valid    = ov_q;
  assign o_overflow = ovf_q;
  assign o_busy     = ~q_empty | q_full | (os_q != OUT_IDLE) | (pair_q == WAIT_Q);

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Directed bench for qpsk_symbol_mapper. Two instances share the inputs:
// dut1 (UPSAMPLE=1) and dut4 (UPSAMPLE=4). Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
module tb_qpsk_symbol_mapper;

  localparam int P = 8192;
  localparam int N = -8192;

  logic        clk = 1'b0;
  logic        rst_n, sync, data, valid, ready;
  logic [31:0] d1, d4;
  logic        v1, v4, ovf1, ovf4, busy1, busy4;
  int          npass = 0;
  int          nfail = 0;
  int          ncheck = 0;

  logic [3:0]  ci, cq;
  logic [31:0] ex [4];

  always #5 clk = ~clk;

  qpsk_symbol_mapper #(.SAMPLE_W(16), .AMPL(8192), .UPSAMPLE(1), .QDEPTH(2)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_sync(sync), .i_data(data), .i_valid(valid),
    .o_data(d1), .o_valid(v1), .i_ready(ready), .o_overflow(ovf1), .o_busy(busy1)
  );

  qpsk_symbol_mapper #(.SAMPLE_W(16), .AMPL(8192), .UPSAMPLE(4), .QDEPTH(2)) dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_sync(sync), .i_data(data), .i_valid(valid),
    .o_data(d4), .o_valid(v4), .i_ready(ready), .o_overflow(ovf4), .o_busy(busy4)
  );

  function automatic logic [31:0] iq(input int i, input int q);
    logic [15:0] a, b;
    a = i[15:0];
    b = q[15:0];
    return {b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncheck++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chip(input logic b);
    valid = 1'b1;
    data  = b;
    tick();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; sync = 1'b0; ready = 1'b1; data = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Four back-to-back dibits (ci/cq) on dut1 with ready=1; each symbol is
  // visible two edges after its Q chip, for exactly one cycle.
  task automatic stream4();
    for (int k = 0; k < 4; k++) begin
      chip(ci[k]);
      if (k > 0) begin
        chk($sformatf("s%0d_valid", k - 1), {31'd0, v1}, 32'd1);
        chk($sformatf("s%0d_data", k - 1), d1, ex[k-1]);
      end
      chip(cq[k]);
      chk($sformatf("gap%0d_valid", k), {31'd0, v1}, 32'd0);
    end
    tick();
    chk("s3_valid", {31'd0, v1}, 32'd1);
    chk("s3_data", d1, ex[3]);
    tick();
    chk("end_valid", {31'd0, v1}, 32'd0);
    chk("end_busy", {31'd0, busy1}, 32'd0);
    chk("end_ovf", {31'd0, ovf1}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; sync = 1'b0; ready = 1'b1; data = 1'b0;
    tick();
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_data", d1, 32'd0);
    chk("rst_ovf", {31'd0, ovf1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);

`ifndef QPSK_DIFF_EN
    // direct mapping: (0,0) (1,0) (0,1) (1,1) as (I,Q) chips
    do_reset();
    ci = 4'b1010; cq = 4'b1100;
    ex[0] = iq(P, P); ex[1] = iq(N, P); ex[2] = iq(P, N); ex[3] = iq(N, N);
    stream4();

    // stall: 6 dibits with ready low; 1 held at output, 2 queued, 3 dropped
    do_reset();
    ready = 1'b0;
    chip(0); chip(0); chip(1); chip(0); chip(0); chip(1);
    chk("stall_ovf_early", {31'd0, ovf1}, 32'd0);
    chk("stall_hold0", d1, iq(P, P));
    for (int k = 0; k < 3; k++) begin chip(1); chip(1); end
    chk("stall_ovf", {31'd0, ovf1}, 32'd1);
    chk("stall_valid", {31'd0, v1}, 32'd1);
    chk("stall_hold1", d1, iq(P, P));
    tick(); tick();
    chk("stall_hold2", d1, iq(P, P));
    ready = 1'b1;
    tick();
    chk("drain1_valid", {31'd0, v1}, 32'd1);
    chk("drain1_data", d1, iq(N, P));
    tick();
    chk("drain2_data", d1, iq(P, N));
    tick();
    chk("drain_done", {31'd0, v1}, 32'd0);
    chk("drain_ovf_sticky", {31'd0, ovf1}, 32'd1);
`else
    // differential: four dibits I=1,Q=0 -> acc 1,2,3,0
    do_reset();
    ci = 4'b1111; cq = 4'b0000;
    ex[0] = iq(N, P); ex[1] = iq(N, N); ex[2] = iq(P, N); ex[3] = iq(P, P);
    stream4();
`endif

    // UPSAMPLE=4: chips 1,1 -> symbol then three zeros
    do_reset();
    chip(1); chip(1);
    chk("up_lat_valid", {31'd0, v4}, 32'd0);
    tick();
    chk("up_sym_valid", {31'd0, v4}, 32'd1);
    chk("up_sym_data", d4, iq(N, N));
    for (int z = 0; z < 3; z++) begin
      tick();
      chk($sformatf("up_zero%0d_valid", z), {31'd0, v4}, 32'd1);
      chk($sformatf("up_zero%0d_data", z), d4, 32'd0);
    end
    chk("up_busy_last", {31'd0, busy4}, 32'd1);
    tick();
    chk("up_idle_valid", {31'd0, v4}, 32'd0);
    chk("up_idle_busy", {31'd0, busy4}, 32'd0);

    // sync: chip 1, then sync together with a chip (dropped), then 0,1
    do_reset();
    chip(1);
    chk("sync_half_busy", {31'd0, busy1}, 32'd1);
    sync = 1'b1; valid = 1'b1; data = 1'b1;
    tick();
    sync = 1'b0; valid = 1'b0;
    chk("sync_busy", {31'd0, busy1}, 32'd0);
    chip(0); chip(1);
    chk("sync_lat_valid", {31'd0, v1}, 32'd0);
    tick();
    chk("sync_valid", {31'd0, v1}, 32'd1);
    chk("sync_data", d1, iq(P, N));
    tick();
    chk("sync_single", {31'd0, v1}, 32'd0);

    // async reset during a zero run with a symbol still queued
    do_reset();
    chip(1); chip(1); chip(0); chip(0);
    chk("mid_zero_valid", {31'd0, v4}, 32'd1);
    chk("mid_zero_data", d4, 32'd0);
    chk("mid_busy", {31'd0, busy4}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_valid", {31'd0, v4}, 32'd0);
    chk("mid_async_busy", {31'd0, busy4}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("mid_post_quiet", {31'd0, v4}, 32'd0);
    chip(0); chip(1);
    tick();
    chk("mid_new_valid", {31'd0, v4}, 32'd1);
    chk("mid_new_data", d4, iq(P, N));
    chk("mid_ovf", {31'd0, ovf4}, 32'd0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", npass, ncheck);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qpsk_symbol_mapper.md
Name: qpsk_symbol_mapper

Overview:
- Sits between the chip FIFO (serial spread chips, valid-qualified) and the FIR interpolation filter.
- Pairs consecutive chips into dibits (first chip -> I, second -> Q) and maps each dibit to a signed QPSK constellation point.
- Optionally inserts zero samples to upsample the symbol stream.
- Drives the FIR input with a valid/ready handshake through a 2-entry symbol queue.

Parameters:
- SAMPLE_W, 16: width of each I and Q sample, two's complement.
- AMPL, 8192: constellation magnitude; must satisfy 0 < AMPL < 2^(SAMPLE_W-1).
- UPSAMPLE, 1: output samples per symbol. 1 = no stuffing; N>1 = symbol followed by N-1 zero samples.
- QDEPTH, 2: symbol queue depth, power of two, >= 2.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous reset, active-low
- i_sync  in  1  synchronous pulse: discard half-built dibit, restart pairing with next chip as I
- i_data  in  1  chip from FIFO
- i_valid  in  1  i_data valid this cycle; no backpressure toward FIFO
- o_data  out  2*SAMPLE_W  sample, [SAMPLE_W-1:0]=I, [2*SAMPLE_W-1:SAMPLE_W]=Q
- o_valid  out  1  o_data valid
- i_ready  in  1  FIR s_axis_data_tready
- o_overflow  out  1  sticky: a symbol was dropped because the queue was full
- o_busy  out  1  queue non-empty, zero run in progress, or dibit half-built

Behaviour:
- Reset (i_reset=0, async): o_valid=0, o_data=0, o_overflow=0, o_busy=0, queue empty, pairing state WAIT_I, zero counter 0, differential accumulator 0.

Pairing FSM:
- WAIT_I: on i_valid, latch i_data as b_i, go to WAIT_Q.
- WAIT_Q: on i_valid, form dibit {b_q=i_data, b_i}, push the mapped symbol, return to WAIT_I.
- i_sync forces WAIT_I and has priority over i_valid in the same cycle; that chip is dropped.

Mapping (direct):
- Bit 0 -> +AMPL, bit 1 -> -AMPL, independently for I and Q.
- Values are computed at full SAMPLE_W width, with no saturation needed.
- Latency: second chip's i_valid at cycle n -> symbol in queue at n+1 -> o_valid no earlier than n+2 (registered output).

Queue:
- QDEPTH entries, read/write pointers with wrap-around.
- Push and pop in the same cycle are both honoured, including when full (pop frees the slot first).
- Push when full with no pop: symbol dropped, o_overflow set until reset; queue contents unchanged.

Output sequencer:
- States OUT_IDLE, OUT_SYM, OUT_ZERO.
- OUT_SYM presents the queue head with o_valid=1.
- Transfer occurs when o_valid&i_ready. o_data and o_valid are held stable while i_ready=0.
- After a symbol transfer:
  - If UPSAMPLE>1: go to OUT_ZERO and present o_data=0 with o_valid=1 for exactly UPSAMPLE-1 transfers, then proceed to the next symbol or OUT_IDLE.
  - If UPSAMPLE=1: proceed directly.
- A back-to-back symbol is available on the cycle after the transfer; full throughput is 1 sample/clock.
- The zero counter is sized $clog2(UPSAMPLE)+1 and wraps only through state exit.

Reset mid-operation:
- An asynchronous assert clears everything immediately.
- Release is not required to preserve any partial symbol.

Optional Feature:
- Macro: QPSK_DIFF_EN.
- Defined: differential QPSK.
  - Dibit index d = {b_q, b_i} Gray-decoded: 00->0, 01->1, 11->2, 10->3.
  - acc <= (acc + d) mod 4 on each completed dibit, including dropped ones, so phase stays continuous.
  - Phase map: 0 -> (+,+), 1 -> (-,+), 2 -> (-,-), 3 -> (+,-).
  - acc resets to 0; i_sync does not clear acc.
- Undefined: direct mapping only; no acc register is synthesised.

Decomposition:
- Package qpsk_pkg:
  - Typedef sample_t (signed SAMPLE_W).
  - Typedef iq_t struct {q, i}.
  - Pairing and output FSM state enums.
  - Function map_dibit(bits, ampl) returning iq_t.
  - Gray-decode table constants.
- Sub-module sym_queue: parameterised QDEPTH-entry synchronous FIFO of iq_t, with full/empty flags and a push-drop indication.

Test Plan:
- Reset, UPSAMPLE=1, i_ready=1, chips 0,0,1,0,0,1,1,1 -> o_data I/Q = (+8192,+8192), (-8192,+8192), (+8192,-8192), (-8192,-8192); each o_valid exactly 2 cycles after its second chip; o_overflow=0.
- UPSAMPLE=4, chips 1,1 -> one sample (-8192,-8192) then three (0,0) samples on consecutive cycles; o_busy deasserts after the last.
- i_ready=0 held, 6 dibits delivered (QDEPTH=2) -> first symbol waits at the output while 2 more fill the queue; remaining 3 dropped; o_overflow=1; on i_ready=1 exactly 3 symbols emerge in order; o_data stable while stalled.
- Chip 1, i_sync pulse, chips 0,1 -> single symbol I=+8192, Q=-8192; the pre-sync chip is discarded.
- QPSK_DIFF_EN defined, dibits 01,01,01,01 (I=1,Q=0) -> acc 1,2,3,0 -> (-,+), (-,-), (+,-), (+,+) at magnitude 8192.
- Assert i_reset low during OUT_ZERO with the queue non-empty -> o_valid=0 the same cycle (async); after release the first output comes only from newly paired chips; o_overflow=0.
